submod_driver: RTL and testbench
================================

# submod_driver

Stimulus source for `submod`. Buffers up to DEPTH frames (8-bit logic value, four longints, four reals) through a valid/ready load port. On `start`, replays the frames back-to-back onto `logic_sig` / `unpacked_ints` / `unpacked_reals`. Each frame is held for a programmed number of cycles. Sits in the DPI test bench between the DPI-fed sequence layer and the `submod` inputs, so frames are scheduled by cycle rather than written directly from DPI.

## Interface
- `DEPTH`, default 4, frame FIFO depth; power of two, ≥2.
- `HOLD_W`, default 8, width of the per-frame hold count.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `load_valid`  in  1  frame offered on the `load_*` inputs.
- `load_ready`  out  1  FIFO can accept a frame; equals `!full`.
- `load_sig`  in  8  frame logic value.
- `load_ints`  in  longint[4]  frame integer values.
- `load_reals`  in  real[4]  frame real values.
- `load_hold`  in  HOLD_W  cycles the frame is driven; 0 is treated as 1.
- `start`  in  1  one-cycle request to begin playback.
- `logic_sig`  out  8  to `submod.logic_sig`.
- `unpacked_ints`  out  longint[4]  to `submod.unpacked_ints`.
- `unpacked_reals`  out  real[4]  to `submod.unpacked_reals`.
- `frame_strobe`  out  1  high for one cycle when a new frame appears on the outputs.
- `busy`  out  1  FSM not in IDLE.
- `count`  out  $clog2(DEPTH+1)  frames currently stored.

## Operation
- **Load**
  - A frame, including its hold value, is written when `load_valid && load_ready`.
  - Write pointer wraps modulo DEPTH.
  - `load_valid` while full is ignored. The frame is not stored and nothing is overwritten.
- **FSM states:** IDLE, PLAY.
- **IDLE**
  - Outputs keep their last driven values.
  - `start` with `count>0`: pop the head frame, register it onto the outputs, load the hold counter with `max(load_hold,1)-1`, then go to PLAY.
  - `start` with `count==0`: ignored; stay in IDLE.
- **PLAY**
  - While the hold counter is non-zero, decrement it.
  - When the hold counter is zero and the FIFO is non-empty: pop the next frame, drive it, pulse `frame_strobe`, and reload the hold counter.
  - When the hold counter is zero and the FIFO is empty: go to IDLE; outputs stay at the last frame.
  - `start` in PLAY is ignored.
- **Simultaneous load and pop:** both happen; `count` is unchanged.
  - A load in the same cycle as a PLAY pop decision does not count toward that decision's empty test. The test uses registered `count`.
  - A frame loaded before that cycle is played with no gap.
- **Reset, including mid-playback:**
  - FSM returns to IDLE.
  - FIFO is emptied (pointers 0, `count`=0) and the hold counter is cleared.
  - `logic_sig`=0, `unpacked_ints`={0,0,0,0}, `unpacked_reals`={0.0,0.0,0.0,0.0}.
  - `frame_strobe`=0, `busy`=0, `load_ready`=1.

## Timing
- **Load:** frame accepted at edge E gives `count`+1 visible after E. `load_ready` deasserts after the edge that fills the FIFO.
- **Start latency:** `start` sampled at edge N.
  - First frame on the outputs, `frame_strobe`=1 and `busy`=1 in the cycle after N (N+1).
- **Hold:** a frame with hold H is driven for exactly `max(H,1)` cycles.
  - Next frame appears at cycle N+1+max(H,1); it gets a strobe and there are no idle cycles between frames.
- **End of playback:** after the last frame's hold expires, `busy` falls in the following cycle. `frame_strobe` is 0 while `busy` is 0.
- **Restart:** `start` may be issued in the first IDLE cycle.

## Test plan
- **Reset values:** assert `rst` for 3 cycles → all outputs 0 / 0.0, `count`=0, `load_ready`=1, `busy`=0.
- **Basic playback:**
  - Stimulus: load frames A (sig 8'h11, ints {1,2,3,4}, reals {0.5,1.5,2.5,3.5}, hold 2) and B (sig 8'hA5, ints {-1,0,1<<40,7}, reals {-1.0,0.0,1e3,2.25}, hold 0); then `start`.
  - Required: A for 2 cycles, then B for 1 cycle, with a strobe on each new frame. `busy` is high for 3 cycles, then the outputs stay at B.
- **Full FIFO and wrap:** load 5 frames with DEPTH=4 → 5th is dropped (`count`=4, `load_ready`=0). Play all 4, load 4 more, play again → correct order across pointer wrap.
- **Load during playback:** load 1 frame with hold 5, `start`, then load a 2nd frame 2 cycles later → 2nd frame follows with no gap and exactly 2 strobes.
- **Ignored start:** `start` with an empty FIFO → `busy` stays 0. `start` pulsed in PLAY → no restart, and the frame sequence is unchanged.
- **Reset mid-operation:** assert `rst` in the middle of the 2nd frame of 3 → outputs go to 0 immediately (asynchronous) and `count`=0. After reset, a subsequent `start` is ignored.

Source files
------------

// File: rtl/submod_driver.sv
`default_nettype none
// submod_driver: buffers up to DEPTH stimulus frames and replays them onto the
// submod inputs, each frame held for its own programmed number of cycles.
module submod_driver #(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [7:0]                   load_sig,
  input  longint                       load_ints [4],
  input  real                          load_reals [4],
  input  logic [HOLD_W-1:0]            load_hold,
  input  logic                         start,
  output logic [7:0]                   logic_sig,
  output longint                       unpacked_ints [4],
  output real                          unpacked_reals [4],
  output logic                         frame_strobe,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t            state;
  state_t            next_state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] head_hold;
  logic [HOLD_W-1:0] hold_init;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  logic [7:0]        mem_sig   [DEPTH];
  longint            mem_ints  [DEPTH][4];
  real               mem_reals [DEPTH][4];
  logic [HOLD_W-1:0] mem_hold  [DEPTH];

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign load_ready = !full;
  assign push       = load_valid && !full;
  assign busy       = (state == PLAY);
  assign head_hold  = mem_hold[rd_ptr];
  // A hold of 0 behaves as 1, so the counter starts at max(H,1)-1.
  assign hold_init  = (head_hold == '0) ? '0 : head_hold - HOLD_W'(1);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_sig[wr_ptr]  <= load_sig;
      mem_hold[wr_ptr] <= load_hold;
      for (int j = 0; j < 4; j++) begin
        mem_ints[wr_ptr][j]  <= load_ints[j];
        mem_reals[wr_ptr][j] <= load_reals[j];
      end
    end
  end

  // Pop decisions look only at the registered count; a same-cycle load waits.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (start && !empty) begin
          pop        = 1'b1;
          next_state = PLAY;
        end
      end
      PLAY: begin
        if (hold_cnt == '0) begin
          if (!empty) pop = 1'b1;
          else        next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      hold_cnt     <= '0;
      frame_strobe <= 1'b0;
      logic_sig    <= '0;
      for (int j = 0; j < 4; j++) begin
        unpacked_ints[j]  <= 64'sd0;
        unpacked_reals[j] <= 0.0;
      end
    end else begin
      state        <= next_state;
      frame_strobe <= pop;
      count        <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        hold_cnt  <= hold_init;
        logic_sig <= mem_sig[rd_ptr];
        for (int j = 0; j < 4; j++) begin
          unpacked_ints[j]  <= mem_ints[rd_ptr][j];
          unpacked_reals[j] <= mem_reals[rd_ptr][j];
        end
      end else if (state == PLAY && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_submod_driver.sv
`default_nettype none
// tb_submod_driver: directed, self-checking bench for submod_driver.
module tb_submod_driver;

  localparam int DEPTH  = 4;
  localparam int HOLD_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_valid;
  logic              load_ready;
  logic [7:0]        load_sig;
  longint            load_ints [4];
  real               load_reals [4];
  logic [HOLD_W-1:0] load_hold;
  logic              start;
  logic [7:0]        logic_sig;
  longint            unpacked_ints [4];
  real               unpacked_reals [4];
  logic              frame_strobe;
  logic              busy;
  logic [2:0]        count;

  submod_driver #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_sig       (load_sig),
    .load_ints      (load_ints),
    .load_reals     (load_reals),
    .load_hold      (load_hold),
    .start          (start),
    .logic_sig      (logic_sig),
    .unpacked_ints  (unpacked_ints),
    .unpacked_reals (unpacked_reals),
    .frame_strobe   (frame_strobe),
    .busy           (busy),
    .count          (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame table; index 16 is the all-zero reset frame.
  logic [7:0]  fsig   [17];
  longint      fints  [17][4];
  real         freals [17][4];
  logic [7:0]  fhold  [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input int f);
    bit ok;
    ok = (logic_sig === fsig[f]);
    for (int j = 0; j < 4; j++)
      ok &= (unpacked_ints[j] === fints[f][j]) && (unpacked_reals[j] == freals[f][j]);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s: observed sig=%0h ints=%0d,%0d,%0d,%0d reals=%f,%f,%f,%f expected frame %0d sig=%0h ints=%0d,%0d,%0d,%0d reals=%f,%f,%f,%f",
             tag, logic_sig, unpacked_ints[0], unpacked_ints[1], unpacked_ints[2], unpacked_ints[3],
             unpacked_reals[0], unpacked_reals[1], unpacked_reals[2], unpacked_reals[3],
             f, fsig[f], fints[f][0], fints[f][1], fints[f][2], fints[f][3],
             freals[f][0], freals[f][1], freals[f][2], freals[f][3]);
    end
  endtask

  task automatic set_load(input int f);
    load_sig  = fsig[f];
    load_hold = fhold[f];
    for (int j = 0; j < 4; j++) begin
      load_ints[j]  = fints[f][j];
      load_reals[j] = freals[f][j];
    end
  endtask

  // Called in the first cycle after start: frames first..first+n-1 back to back.
  task automatic play_expect(input int first, input int n);
    int h;
    for (int k = 0; k < n; k++) begin
      h = (fhold[first+k] == 8'd0) ? 1 : int'(fhold[first+k]);
      for (int c = 0; c < h; c++) begin
        chk_frame("play_frame", first + k);
        chk("play_strobe", 64'(frame_strobe), 64'(c == 0));
        chk("play_busy", 64'(busy), 64'd1);
        tick();
      end
    end
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_strobe", 64'(frame_strobe), 64'd0);
    chk_frame("end_hold_last", first + n - 1);
  endtask

  initial begin
    int strobes;
    int ef;

    for (int i = 0; i < 17; i++) begin
      fsig[i]  = 8'(i * 16 + 3);
      fhold[i] = 8'd1;
      for (int j = 0; j < 4; j++) begin
        fints[i][j]  = longint'(i * 100 + j);
        freals[i][j] = real'(i) + 0.25 * real'(j);
      end
    end
    fsig[0] = 8'h11; fhold[0] = 8'd2;
    fints[0][0] = 1; fints[0][1] = 2; fints[0][2] = 3; fints[0][3] = 4;
    freals[0][0] = 0.5; freals[0][1] = 1.5; freals[0][2] = 2.5; freals[0][3] = 3.5;
    fsig[1] = 8'hA5; fhold[1] = 8'd0;
    fints[1][0] = -1; fints[1][1] = 0; fints[1][2] = longint'(1) << 40; fints[1][3] = 7;
    freals[1][0] = -1.0; freals[1][1] = 0.0; freals[1][2] = 1e3; freals[1][3] = 2.25;
    fhold[2] = 8'd1; fhold[3] = 8'd0; fhold[4] = 8'd2; fhold[5] = 8'd1;
    fhold[7] = 8'd3; fhold[8] = 8'd0; fhold[9] = 8'd2; fhold[10] = 8'd1;
    fhold[11] = 8'd5; fhold[12] = 8'd2;
    fhold[13] = 8'd3; fhold[14] = 8'd3; fhold[15] = 8'd3;
    fsig[16] = 8'h00; fhold[16] = 8'd0;
    for (int j = 0; j < 4; j++) begin
      fints[16][j]  = 0;
      freals[16][j] = 0.0;
    end

    rst = 1'b1; load_valid = 1'b0; start = 1'b0;
    set_load(16);
    repeat (3) @(posedge clk);
    #1;
    chk_frame("reset_outputs", 16);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_load_ready", 64'(load_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_strobe", 64'(frame_strobe), 64'd0);
    rst = 1'b0;
    tick();

    // Basic playback: A (hold 2) then B (hold 0 -> 1 cycle).
    set_load(0); load_valid = 1'b1;
    tick();
    chk("basic_count1", 64'(count), 64'd1);
    set_load(1);
    tick();
    chk("basic_count2", 64'(count), 64'd2);
    load_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    play_expect(0, 2);

    // Start with an empty FIFO is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_start_busy", 64'(busy), 64'd0);
    chk("empty_start_strobe", 64'(frame_strobe), 64'd0);
    chk_frame("empty_start_hold", 1);
    tick();
    chk("empty_start_busy2", 64'(busy), 64'd0);

    // Fill past DEPTH: the fifth frame is dropped.
    load_valid = 1'b1;
    for (int f = 2; f <= 6; f++) begin
      set_load(f);
      tick();
      chk("fill_count", 64'(count), 64'((f - 1 > 4) ? 4 : f - 1));
      chk("fill_load_ready", 64'(load_ready), 64'(f - 1 < 4));
    end
    load_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    play_expect(2, 4);

    // Second batch crosses the pointer wrap.
    load_valid = 1'b1;
    for (int f = 7; f <= 10; f++) begin
      set_load(f);
      tick();
    end
    load_valid = 1'b0;
    chk("wrap_count", 64'(count), 64'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    play_expect(7, 4);

    // Load during playback plus a start pulse while playing.
    set_load(11); load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    strobes = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      ef = (cyc <= 5) ? 11 : 12;
      chk_frame("live_frame", ef);
      chk("live_busy", 64'(busy), 64'(cyc <= 7));
      chk("live_strobe", 64'(frame_strobe), 64'(cyc == 1 || cyc == 6));
      if (frame_strobe) strobes++;
      if (cyc == 2) set_load(12);
      load_valid = (cyc == 2);
      start      = (cyc == 3);
      tick();
    end
    load_valid = 1'b0;
    start = 1'b0;
    chk("live_strobe_total", 64'(strobes), 64'd2);

    // Asynchronous reset in the middle of the second of three frames.
    load_valid = 1'b1;
    for (int f = 13; f <= 15; f++) begin
      set_load(f);
      tick();
    end
    load_valid = 1'b0;
    chk("mid_count", 64'(count), 64'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk_frame("mid_pre_reset", 14);
    chk("mid_pre_reset_count", 64'(count), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk_frame("mid_reset_outputs", 16);
    chk("mid_reset_count", 64'(count), 64'd0);
    chk("mid_reset_busy", 64'(busy), 64'd0);
    chk("mid_reset_strobe", 64'(frame_strobe), 64'd0);
    chk("mid_reset_load_ready", 64'(load_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_strobe", 64'(frame_strobe), 64'd0);
    chk_frame("post_reset_outputs", 16);
    tick();
    chk("post_reset_busy2", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
